// File: rtl/uart_loopback_fifo.sv
// UART loopback bridge: serial receive into a circular FIFO, optional per-word
// transform at pop time, and retransmission with flow control and sticky error flags.
module uart_loopback_fifo #(
    parameter int IN_FREQ    = 220052,
    parameter int OUT_FREQ   = 96,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic [1:0]                    mode,
    input  logic                          tx_en,
    input  logic                          clear_flags,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          rx_strobe,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_err
);
    localparam int CPB = IN_FREQ / OUT_FREQ;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(STOP_BITS * CPB + 1);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * CPB - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // Case swap only makes sense for 8-bit ASCII; other widths pass through.
    function automatic logic [DATA_BITS-1:0] xform(input logic [1:0] m, input logic [DATA_BITS-1:0] w);
        logic [8:0] wx;
        logic [DATA_BITS-1:0] r;
        wx = 9'(w);
        r  = w;
        case (m)
            2'b01:   r = ~w;
            2'b10:   if (DATA_BITS == 8 && ((wx >= 9'h041 && wx <= 9'h05A) || (wx >= 9'h061 && wx <= 9'h07A)))
                         r = DATA_BITS'(wx ^ 9'h020);
                     else
                         r = w;
            default: r = w;
        endcase
        return r;
    endfunction

    logic rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [BW-1:0] rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    tx_state_t tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [BW-1:0] tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic tx_q, tx_d, tx_busy_q, tx_busy_d, rx_strobe_q, rx_strobe_d;
    logic overflow_q, overflow_d, frame_err_q, frame_err_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic push_s, pop_s, full_s, ovf_set_s, ferr_set_s;

    assign full_s = (count_q == FULL_CNT);
    assign pop_s  = (tx_state_q == TX_IDLE) && tx_en && (count_q != '0);

    // Receiver: sample mid-bit from the start-bit midpoint; a full FIFO still accepts if a pop coincides.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        push_s     = 1'b0;
        ovf_set_s  = 1'b0;
        ferr_set_s = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
                else                         rx_state_d = RX_IDLE;
            end
            RX_START: begin
                if (rx_cnt_q == HALF_END) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
                    else                      rx_bit_d   = rx_bit_q + BW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d = '0;
                    if (!rx_sync_q) begin
                        ferr_set_s = 1'b1;
                        rx_state_d = RX_WAIT;
                    end else begin
                        rx_state_d = RX_IDLE;
                        if (!full_s || pop_s) push_s    = 1'b1;
                        else                  ovf_set_s = 1'b1;
                    end
                end
            end
            RX_WAIT: begin
                rx_cnt_d   = '0;
                rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Transmitter: a drop-mode pop consumes the word without leaving idle.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_busy_d  = tx_busy_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d  = '0;
                tx_d      = 1'b1;
                tx_busy_d = 1'b0;
                if (pop_s && mode != 2'b11) begin
                    tx_state_d = TX_START;
                    tx_d       = 1'b0;
                    tx_busy_d  = 1'b1;
                    tx_shift_d = xform(mode, mem_q[rd_ptr_q]);
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == LAST_BIT) begin
                        tx_d       = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_d     = tx_shift_q[1];
                        tx_bit_d = tx_bit_q + BW'(1);
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == STOP_END) begin
                    tx_cnt_d   = '0;
                    tx_busy_d  = 1'b0;
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // FIFO bookkeeping and sticky flags; a set event beats a same-cycle clear.
    always_comb begin
        wr_ptr_d    = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q + (AW+1)'(push_s) - (AW+1)'(pop_s);
        rx_strobe_d = push_s;
        if (ovf_set_s)        overflow_d = 1'b1;
        else if (clear_flags) overflow_d = 1'b0;
        else                  overflow_d = overflow_q;
        if (ferr_set_s)       frame_err_d = 1'b1;
        else if (clear_flags) frame_err_d = 1'b0;
        else                  frame_err_d = frame_err_q;
    end

    // State registers, including the rx synchronizer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_q        <= 1'b1;
            tx_busy_q   <= 1'b0;
            rx_strobe_q <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            tx_busy_q   <= tx_busy_d;
            rx_strobe_q <= rx_strobe_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage; contents are don't-care after reset since pointers clear.
    always_ff @(posedge clk) begin
        if (push_s) mem_q[wr_ptr_q] <= rx_shift_q;
    end

    assign tx         = tx_q;
    assign tx_busy    = tx_busy_q;
    assign rx_strobe  = rx_strobe_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Self-checking bench for uart_loopback_fifo: frames are decoded off tx and
// compared against a queue-based reference of what the bridge should emit.
module tb_uart_loopback_fifo;
    localparam int CPB = 20;

    logic clk = 1'b0;
    logic reset, rx, tx_en, clear_flags;
    logic [1:0] mode;
    logic tx, tx_busy, rx_strobe, overflow, frame_err;
    logic [2:0] fifo_count;

    int checks_n = 0;
    int errors_n = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int last_strobe_cyc = 0;
    bit mon_en = 1'b1;
    logic tx_prev = 1'b1;
    logic [7:0] exp_q[$];
    int starts_q[$];

    uart_loopback_fifo #(
        .IN_FREQ(20), .OUT_FREQ(1), .DATA_BITS(8), .FIFO_DEPTH(4), .STOP_BITS(1)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .mode(mode), .tx_en(tx_en),
        .clear_flags(clear_flags), .tx(tx), .tx_busy(tx_busy), .rx_strobe(rx_strobe),
        .fifo_count(fifo_count), .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_strobe === 1'b1) begin
            strobe_cnt      <= strobe_cnt + 1;
            last_strobe_cyc <= cyc;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            errors_n++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_xform(input logic [1:0] m, input logic [7:0] d);
        if (m == 2'd1) return ~d;
        if (m == 2'd2 && ((d >= 8'h41 && d <= 8'h5A) || (d >= 8'h61 && d <= 8'h7A))) return d ^ 8'h20;
        return d;
    endfunction

    task automatic send_word(input logic [7:0] d, input logic stop_v);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_v;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || tx_busy !== 1'b0 || fifo_count !== 3'd0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_val("drain_done", {31'd0, t < 3000}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Frame monitor: samples every bit at its midpoint and measures tx_busy width.
    initial begin : monitor
        logic [9:0] bits;
        logic [7:0] w;
        int k;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx_prev === 1'b1 && tx === 1'b0 && mon_en) begin
                starts_q.push_back(cyc);
                bits = '1;
                k = 0;
                while (tx_busy === 1'b1 && k < 300) begin
                    if (k % CPB == CPB / 2 && k / CPB < 10) bits[k / CPB] = tx;
                    @(negedge clk);
                    k++;
                end
                check_val("busy_len", k, 200);
                check_val("start_bit", {31'd0, bits[0]}, 32'd0);
                check_val("stop_bit", {31'd0, bits[9]}, 32'd1);
                w = bits[8:1];
                if (exp_q.size() > 0) check_val("tx_word", {24'd0, w}, {24'd0, exp_q.pop_front()});
                else                  check_val("unexpected_frame", {24'd0, w}, 32'h100);
            end
            tx_prev = tx;
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int s0;
        logic [7:0] d;
        logic [1:0] m;
        logic [7:0] case_words [3];
        int model_cnt;

        reset = 1'b1; rx = 1'b1; tx_en = 1'b0; mode = 2'b00; clear_flags = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_tx", {31'd0, tx}, 32'd1);
        check_val("rst_busy", {31'd0, tx_busy}, 32'd0);
        check_val("rst_strobe", {31'd0, rx_strobe}, 32'd0);
        check_val("rst_count", {29'd0, fifo_count}, 32'd0);
        check_val("rst_ovf", {31'd0, overflow}, 32'd0);
        check_val("rst_ferr", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Plain echo, with strobe-to-start latency.
        tx_en = 1'b1;
        starts_q.delete();
        s0 = strobe_cnt;
        exp_q.push_back(8'h8E);
        send_word(8'h8E, 1'b1);
        check_val("echo_strobes", strobe_cnt - s0, 1);
        wait_drain();
        check_val("echo_frames", starts_q.size(), 1);
        if (starts_q.size() > 0) check_val("strobe_to_start", starts_q[0] - last_strobe_cyc, 1);

        // Invert.
        mode = 2'b01;
        exp_q.push_back(ref_xform(2'b01, 8'h8E));
        send_word(8'h8E, 1'b1);
        wait_drain();

        // Case swap at and beyond the letter boundaries.
        mode = 2'b10;
        case_words[0] = 8'h61; case_words[1] = 8'h5A; case_words[2] = 8'h7B;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ref_xform(2'b10, case_words[i]));
            send_word(case_words[i], 1'b1);
        end
        wait_drain();

        // Randomized words and modes.
        for (int i = 0; i < 6; i++) begin
            m = 2'($urandom_range(0, 2));
            d = 8'($urandom);
            mode = m;
            exp_q.push_back(ref_xform(m, d));
            send_word(d, 1'b1);
            wait_drain();
        end

        // Fill past capacity with tx disabled, then drain back-to-back.
        mode = 2'b00;
        tx_en = 1'b0;
        s0 = strobe_cnt;
        model_cnt = 0;
        for (int i = 1; i <= 5; i++) begin
            if (model_cnt < 4) begin
                exp_q.push_back(8'(i));
                model_cnt++;
            end
            send_word(8'(i), 1'b1);
        end
        check_val("fill_count", {29'd0, fifo_count}, model_cnt);
        check_val("fill_ovf", {31'd0, overflow}, 32'd1);
        check_val("fill_strobes", strobe_cnt - s0, model_cnt);
        starts_q.delete();
        tx_en = 1'b1;
        wait_drain();
        check_val("drain_frames", starts_q.size(), 4);
        for (int i = 1; i < starts_q.size(); i++)
            check_val("frame_spacing", starts_q[i] - starts_q[i-1], 201);
        check_val("drain_count", {29'd0, fifo_count}, 32'd0);

        // Flags: clear, glitch, framing error.
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        check_val("clr_ovf", {31'd0, overflow}, 32'd0);
        check_val("clr_ferr", {31'd0, frame_err}, 32'd0);
        tx_en = 1'b0;
        exp_q.push_back(8'h3C);
        send_word(8'h3C, 1'b1);
        s0 = strobe_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check_val("glitch_strobes", strobe_cnt - s0, 0);
        check_val("glitch_ferr", {31'd0, frame_err}, 32'd0);
        check_val("glitch_ovf", {31'd0, overflow}, 32'd0);
        check_val("glitch_count", {29'd0, fifo_count}, 32'd1);
        send_word(8'hA5, 1'b0);
        check_val("ferr_set", {31'd0, frame_err}, 32'd1);
        check_val("ferr_ovf", {31'd0, overflow}, 32'd0);
        check_val("ferr_strobes", strobe_cnt - s0, 0);
        check_val("ferr_count", {29'd0, fifo_count}, 32'd1);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        check_val("ferr_clr", {31'd0, frame_err}, 32'd0);
        tx_en = 1'b1;
        wait_drain();

        // Drop mode drains one word per cycle without a frame.
        tx_en = 1'b0;
        for (int i = 0; i < 3; i++) send_word(8'($urandom), 1'b1);
        check_val("drop_fill", {29'd0, fifo_count}, 32'd3);
        mode = 2'b11;
        tx_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("drop_count", {29'd0, fifo_count}, 2 - i);
            check_val("drop_tx", {31'd0, tx}, 32'd1);
            check_val("drop_busy", {31'd0, tx_busy}, 32'd0);
        end
        tx_en = 1'b0;
        mode = 2'b00;
        repeat (5) @(negedge clk);

        // Reset during a start bit.
        mon_en = 1'b0;
        send_word(8'h55, 1'b1);
        send_word(8'hAA, 1'b1);
        check_val("prerst_count", {29'd0, fifo_count}, 32'd2);
        tx_en = 1'b1;
        repeat (3) @(negedge clk);
        check_val("prerst_tx", {31'd0, tx}, 32'd0);
        check_val("prerst_busy", {31'd0, tx_busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_val("midrst_tx", {31'd0, tx}, 32'd1);
        check_val("midrst_count", {29'd0, fifo_count}, 32'd0);
        check_val("midrst_busy", {31'd0, tx_busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
        $finish;
    end
endmodule
